// File: rtl/cpu_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encodings and requester IDs.
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ACCESS    = 2'd1,
    ARB_READ_WAIT = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the CPU and loader requesters.
// DATA_ARB_RR_EN selects round-robin on a tie; otherwise the CPU always wins.
module arb_pick
  import cpu_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

`ifdef DATA_ARB_RR_EN
  always_comb begin
    valid  = req0 | req1;
    winner = REQ_CPU;
    // A tie goes to whoever was not granted last time.
    if (req0 && req1)
      winner = ~last;
    else if (req1)
      winner = REQ_LOADER;
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    valid  = req0 | req1;
    winner = (req1 && !req0) ? REQ_LOADER : REQ_CPU;
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialising two-requester arbiter in front of the single-port data memory.
// Define DATA_ARB_RR_EN for round-robin tie-breaking; the default is fixed priority to requester 0.
module data_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH_DATA = 32,
  parameter int AWIDTH     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [AWIDTH-1:0]     addr0,
  input  logic [AWIDTH-1:0]     addr1,
  input  logic [WIDTH_DATA-1:0] wdata0,
  input  logic [WIDTH_DATA-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [WIDTH_DATA-1:0] rdata,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic [WIDTH_DATA-1:0] mem_wdata,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  input  logic [WIDTH_DATA-1:0] mem_rdata,
  output logic                  busy
);

  arb_state_t state, state_next;
  logic       owner;
  logic       we_q;
  logic       last;
  logic       pick_valid;
  logic       pick_winner;

`ifdef DATA_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst)
      last_q <= REQ_LOADER;
    else if (state == ARB_ACCESS)
      last_q <= owner;
  end

  assign last = last_q;
`else
  assign last = REQ_LOADER;
`endif

  arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= ARB_IDLE;
    else
      state <= state_next;
  end

  // Grants and enables decode from state and registered owner only, so no req reaches an output combinationally.
  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid)
          state_next = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        gnt0       = (owner == REQ_CPU);
        gnt1       = (owner == REQ_LOADER);
        mem_wr_en  = we_q;
        mem_rd_en  = !we_q;
        state_next = we_q ? ARB_IDLE : ARB_READ_WAIT;
      end
      ARB_READ_WAIT: state_next = ARB_IDLE;
      default:       state_next = ARB_IDLE;
    endcase
  end

  assign busy = (state != ARB_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= REQ_CPU;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (state == ARB_IDLE && pick_valid) begin
        owner     <= pick_winner;
        we_q      <= pick_winner ? we1 : we0;
        mem_addr  <= pick_winner ? addr1 : addr0;
        mem_wdata <= pick_winner ? wdata1 : wdata0;
      end
      // Read data lands in the IDLE cycle that follows, alongside the owner's rvalid.
      if (state == ARB_READ_WAIT) begin
        rdata   <= mem_rdata;
        rvalid0 <= (owner == REQ_CPU);
        rvalid1 <= (owner == REQ_LOADER);
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural data memory and per-requester read scoreboards.
module tb_data_mem_arbiter;

  localparam int WD = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [WD-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [WD-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [WD-1:0] mem_wdata;
  logic          mem_rd_en, mem_wr_en;
  logic [WD-1:0] mem_rdata = '0;
  logic          busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {bit id; int cyc;} gnt_ev_t;
  typedef struct {bit id; logic [WD-1:0] data;} rv_ev_t;

  gnt_ev_t       glog[$];
  rv_ev_t        rvlog[$];
  logic [WD-1:0] exp_q0[$];
  logic [WD-1:0] exp_q1[$];

  logic [WD-1:0] mem [0:1023];
  bit            written [0:1023];

  data_mem_arbiter #(.WIDTH_DATA(WD), .AWIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Unwritten locations return a recognisable pattern derived from the address.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    if (mem_rd_en)
      mem_rdata <= written[mem_addr] ? mem[mem_addr] : (32'hA000_0000 | 32'(mem_addr));
  end

  task automatic drive0(input int k, input bit w);
    req0   = 1'b1;
    we0    = w;
    addr0  = w ? 10'(50 + k) : 10'(10 + k);
    wdata0 = 32'h5000_0000 + 32'(k);
    if (!w) exp_q0.push_back(32'hA000_0000 | 32'(10 + k));
  endtask

  task automatic drive1(input int k, input bit w);
    req1   = 1'b1;
    we1    = w;
    addr1  = w ? 10'(70 + k) : 10'(20 + k);
    wdata1 = 32'h7000_0000 + 32'(k);
    if (!w) exp_q1.push_back(32'hA000_0000 | 32'(20 + k));
  endtask

  // Two requesters that each hold a request until granted, then present the next one.
  task automatic run_agents(input int n0, input bit w0, input int n1, input bit w1, input int budget);
    int rem0 = n0;
    int rem1 = n1;
    int k0 = 0;
    int k1 = 0;
    int cyc = 0;
    int rvs = 0;
    int reads = (w0 ? 0 : n0) + (w1 ? 0 : n1);
    glog.delete();
    rvlog.delete();
    if (rem0 > 0) drive0(k0, w0);
    if (rem1 > 0) drive1(k1, w1);
    while ((rem0 > 0 || rem1 > 0 || rvs < reads) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (rvalid0) begin rvlog.push_back('{id: 1'b0, data: rdata}); rvs++; end
      if (rvalid1) begin rvlog.push_back('{id: 1'b1, data: rdata}); rvs++; end
      if (gnt0) begin
        glog.push_back('{id: 1'b0, cyc: cyc});
        rem0--; k0++;
        if (rem0 > 0) drive0(k0, w0); else req0 = 1'b0;
      end
      if (gnt1) begin
        glog.push_back('{id: 1'b1, cyc: cyc});
        rem1--; k1++;
        if (rem1 > 0) drive1(k1, w1); else req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checks++;
    if (rem0 > 0 || rem1 > 0 || rvs < reads) begin
      fails++;
      $display("[TB] FAIL agents_timeout: got grants_left=%0d reads_done=%0d expected 0 and %0d", rem0 + rem1, rvs, reads);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_rd_en, mem_wr_en, busy} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {gnt0, gnt1, rvalid0, rvalid1, mem_rd_en, mem_wr_en, busy});
    end
    checks++;
    if (rdata !== '0) begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    checks++;
    if (mem_addr !== '0) begin fails++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); end
    checks++;
    if (mem_wdata !== '0) begin fails++; $display("[TB] FAIL reset_wdata: got %h expected 0", mem_wdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_write();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd5; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_wr_en, mem_rd_en} !== 4'b1010) begin
      fails++;
      $display("[TB] FAIL write_grant: got gnt0,gnt1,wr,rd=%b expected 1010", {gnt0, gnt1, mem_wr_en, mem_rd_en});
    end
    checks++;
    if (mem_addr !== 10'd5) begin fails++; $display("[TB] FAIL write_addr: got %0d expected 5", mem_addr); end
    checks++;
    if (mem_wdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL write_data: got %h expected deadbeef", mem_wdata); end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, gnt0, mem_wr_en} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL write_done: got busy,gnt0,wr=%b expected 000", {busy, gnt0, mem_wr_en});
    end
  endtask

  task automatic test_read();
    logic [WD-1:0] exp;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd5;
    exp_q1.push_back(32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if ({gnt1, gnt0, mem_rd_en, mem_wr_en} !== 4'b1010) begin
      fails++;
      $display("[TB] FAIL read_grant: got gnt1,gnt0,rd,wr=%b expected 1010", {gnt1, gnt0, mem_rd_en, mem_wr_en});
    end
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, rvalid1} !== 2'b10) begin fails++; $display("[TB] FAIL read_wait: got busy,rvalid1=%b expected 10", {busy, rvalid1}); end
    @(negedge clk);
    checks++;
    if ({rvalid1, rvalid0, busy} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL read_valid: got rvalid1,rvalid0,busy=%b expected 100", {rvalid1, rvalid0, busy});
    end
    exp = exp_q1.pop_front();
    checks++;
    if (rdata !== exp) begin fails++; $display("[TB] FAIL read_data: got %h expected %h", rdata, exp); end
    @(negedge clk);
    checks++;
    if (rvalid1 !== 1'b0 || rdata !== exp) begin
      fails++;
      $display("[TB] FAIL read_hold: got rvalid1=%b rdata=%h expected 0 and %h", rvalid1, rdata, exp);
    end
  endtask

  task automatic test_tie();
    bit first_id;
    logic [WD-1:0] exp;
`ifdef DATA_ARB_RR_EN
    first_id = 1'b1;
`else
    first_id = 1'b0;
`endif
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd30; wdata0 = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin fails++; $display("[TB] FAIL tie_prior_grant: got gnt0=%b expected 1", gnt0); end
    req0 = 1'b0;
    @(negedge clk);
    run_agents(1, 1'b0, 1, 1'b0, 30);
    checks++;
    if (glog.size() != 2) begin
      fails++;
      $display("[TB] FAIL tie_grant_count: got %0d expected 2", glog.size());
    end else begin
      checks++;
      if (glog[0].id !== first_id || glog[1].id !== !first_id) begin
        fails++;
        $display("[TB] FAIL tie_order: got %0d,%0d expected %0d,%0d", glog[0].id, glog[1].id, first_id, !first_id);
      end
      checks++;
      if (glog[1].cyc - glog[0].cyc != 3) begin
        fails++;
        $display("[TB] FAIL tie_spacing: got %0d expected 3", glog[1].cyc - glog[0].cyc);
      end
    end
    checks++;
    if (rvlog.size() != 2) begin fails++; $display("[TB] FAIL tie_rvalid_count: got %0d expected 2", rvlog.size()); end
    foreach (rvlog[i]) begin
      checks++;
      if (rvlog[i].id == 1'b0 && exp_q0.size() > 0) exp = exp_q0.pop_front();
      else if (rvlog[i].id == 1'b1 && exp_q1.size() > 0) exp = exp_q1.pop_front();
      else exp = 'x;
      if (rvlog[i].data !== exp) begin
        fails++;
        $display("[TB] FAIL tie_rdata%0d: got %h expected %h", rvlog[i].id, rvlog[i].data, exp);
      end
    end
  endtask

  task automatic test_reset_in_read_wait();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd5;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin fails++; $display("[TB] FAIL rst_rw_grant: got gnt0=%b expected 1", gnt0); end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin fails++; $display("[TB] FAIL rst_rw_busy: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_rd_en, mem_wr_en, busy} !== 7'b0 || rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      fails++;
      $display("[TB] FAIL rst_rw_outputs: got ctrl=%b rdata=%h addr=%h wdata=%h expected all 0",
               {gnt0, gnt1, rvalid0, rvalid1, mem_rd_en, mem_wr_en, busy}, rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid0, busy} !== 2'b00) begin fails++; $display("[TB] FAIL rst_rw_dropped: got rvalid0,busy=%b expected 00", {rvalid0, busy}); end
  endtask

  task automatic test_alternation();
    bit exp_ids[$];
    int n0;
    logic [WD-1:0] exp;
`ifdef DATA_ARB_RR_EN
    n0 = 3;
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    n0 = 10;
    for (int i = 0; i < 10; i++) exp_ids.push_back(1'b0);
    exp_ids.push_back(1'b1);
    exp_ids.push_back(1'b1);
`endif
    run_agents(n0, 1'b1, 2, 1'b0, 80);
    checks++;
    if (glog.size() != exp_ids.size()) begin
      fails++;
      $display("[TB] FAIL alt_grant_count: got %0d expected %0d", glog.size(), exp_ids.size());
    end else begin
      foreach (exp_ids[i]) begin
        checks++;
        if (glog[i].id !== exp_ids[i]) begin
          fails++;
          $display("[TB] FAIL alt_order[%0d]: got %0d expected %0d", i, glog[i].id, exp_ids[i]);
        end
      end
    end
`ifndef DATA_ARB_RR_EN
    foreach (glog[i]) begin
      if (glog[i].id == 1'b1) begin
        checks++;
        if (glog[i].cyc <= 20) begin
          fails++;
          $display("[TB] FAIL alt_starve: got gnt1 at cycle %0d expected after cycle 20", glog[i].cyc);
        end
      end
    end
`endif
    foreach (rvlog[i]) begin
      exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : 'x;
      checks++;
      if (rvlog[i].id !== 1'b1 || rvlog[i].data !== exp) begin
        fails++;
        $display("[TB] FAIL alt_rdata: got id=%0d data=%h expected id=1 data=%h", rvlog[i].id, rvlog[i].data, exp);
      end
    end
    for (int k = 0; k < n0; k++) begin
      checks++;
      if (mem[50 + k] !== 32'h5000_0000 + 32'(k)) begin
        fails++;
        $display("[TB] FAIL alt_wdata[%0d]: got %h expected %h", k, mem[50 + k], 32'h5000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_withdrawn();
    int g1 = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd80; wdata0 = 32'hCAFE_0080;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin fails++; $display("[TB] FAIL wd_grant0: got %b expected 1", gnt0); end
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd90;
    @(negedge clk);
    req1 = 1'b0;
    checks++;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL wd_idle: got busy=%b expected 0", busy); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gnt1 || busy) g1++;
    end
    checks++;
    if (g1 != 0) begin fails++; $display("[TB] FAIL wd_no_grant: got %0d active cycles expected 0", g1); end
    checks++;
    if (mem[80] !== 32'hCAFE_0080) begin fails++; $display("[TB] FAIL wd_write: got %h expected cafe0080", mem[80]); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_reset_in_read_wait();
    test_alternation();
    test_withdrawn();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
